// File: rtl/kitchen_responder_pkg.sv
// rtl/kitchen_responder_pkg.sv - command codes, target ids and status bit layout for the kitchen responder
package kitchen_responder_pkg;

    localparam logic [1:0] CH_GAME   = 2'b01;
    localparam logic [1:0] CH_ACTION = 2'b10;
    localparam logic [1:0] CH_TARGET = 2'b11;

    localparam logic [7:0] CMD_NONACT  = 8'h00;
    localparam logic [7:0] CMD_START   = 8'h05;
    localparam logic [7:0] CMD_ENDGAME = 8'h09;

    localparam logic [4:0] ACT_GET      = 5'b00001;
    localparam logic [4:0] ACT_PUT      = 5'b00010;
    localparam logic [4:0] ACT_INTERACT = 5'b00100;
    localparam logic [4:0] ACT_MOVE     = 5'b01000;
    localparam logic [4:0] ACT_THROW    = 5'b10000;

    localparam logic [5:0] TGT_FIRST  = 6'd1;
    localparam logic [5:0] DISP_LAST  = 6'd6;
    localparam logic [5:0] MACH_FIRST = 6'd7;
    localparam logic [5:0] MACH_LAST  = 6'd19;
    localparam logic [5:0] BIN_ID     = 6'd20;

    // Per-target vectors are indexed by id; bit 0 is never a legal target.
    localparam int                ID_W           = 21;
    localparam logic [ID_W-1:0]   ID_ONE         = 21'd1;
    localparam logic [ID_W-1:0]   DISPENSER_MASK = 21'h00007e;

    localparam int OB_RUN   = 0;
    localparam int OB_ERR   = 1;
    localparam int OB_AT    = 2;
    localparam int OB_HELD  = 3;
    localparam int OB_READY = 4;
    localparam int OB_ITEM  = 5;

    localparam logic [1:0] GS_IDLE  = 2'd0;
    localparam logic [1:0] GS_RUN   = 2'd1;
    localparam logic [1:0] GS_ENDED = 2'd2;

    typedef struct packed {
        logic start;
        logic endgame;
        logic sel;
        logic get;
        logic put;
        logic interact;
        logic move;
        logic throw_item;
        logic invalid;
    } cmd_strobe_t;

    function automatic logic is_dispenser(input logic [5:0] id);
        return (id >= TGT_FIRST) && (id <= DISP_LAST);
    endfunction

    function automatic logic is_machine(input logic [5:0] id);
        return (id >= MACH_FIRST) && (id <= MACH_LAST);
    endfunction

    function automatic logic is_throwable(input logic [5:0] id);
        return (id == 6'd9) || (id == 6'd11) || (id == 6'd14) ||
               (id == 6'd17) || (id == 6'd19) || (id == BIN_ID);
    endfunction

endpackage

// File: rtl/kitchen_cmd_decode.sv
// rtl/kitchen_cmd_decode.sv - edge detect and decode of in_bits into one-shot command strobes
module kitchen_cmd_decode
    import kitchen_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_bits,
    output cmd_strobe_t strobe,
    output logic [5:0]  id
);
    logic [7:0] prev_bits;
    logic       fire;

    always_ff @(posedge clk) begin
        if (!rst_n) prev_bits <= CMD_NONACT;
        else        prev_bits <= in_bits;
    end

    // A held command fires once; returning to nonact is never a command.
    assign fire = (in_bits != prev_bits) && (in_bits != CMD_NONACT);
    assign id   = in_bits[7:2];

    always_comb begin
        strobe = '0;
        if (fire) begin
            unique case (in_bits[1:0])
                CH_TARGET: strobe.sel = 1'b1;
                CH_ACTION: begin
                    if (in_bits[7]) begin
                        strobe.invalid = 1'b1;
                    end else begin
                        case (in_bits[6:2])
                            ACT_GET:      strobe.get        = 1'b1;
                            ACT_PUT:      strobe.put        = 1'b1;
                            ACT_INTERACT: strobe.interact   = 1'b1;
                            ACT_MOVE:     strobe.move       = 1'b1;
                            ACT_THROW:    strobe.throw_item = 1'b1;
                            default:      strobe.invalid    = 1'b1;
                        endcase
                    end
                end
                CH_GAME: begin
                    if (in_bits == CMD_START)        strobe.start   = 1'b1;
                    else if (in_bits == CMD_ENDGAME) strobe.endgame = 1'b1;
                    else                             strobe.invalid = 1'b1;
                end
                default: strobe.invalid = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/kitchen_responder.sv
// rtl/kitchen_responder.sv - responder end of the kitchen game link: position, items, machines and status
module kitchen_responder
    import kitchen_responder_pkg::*;
#(
    parameter int MOVE_CYCLES = 8,
    parameter int PROC_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_bits,
    output logic [7:0] out_bits,
    output logic [5:0] pos
);
    cmd_strobe_t     strobe;
    logic [5:0]      cmd_id;
    logic [1:0]      game_q, game_n;
    logic [5:0]      tgt_q, tgt_n, pos_n, proc_id_q, proc_id_n;
    logic            held_q, held_n, err_n, at_now, at_next, item_at;
    logic [ID_W-1:0] item_q, item_n, ready_q, ready_n, tgt_oh, tgt_n_oh;
    logic [7:0]      move_q, move_n, proc_q, proc_n, out_n;

    kitchen_cmd_decode u_decode (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_bits (in_bits),
        .strobe  (strobe),
        .id      (cmd_id)
    );

    assign tgt_oh = ID_ONE << tgt_q;

    always_comb begin
        game_n    = game_q;
        pos_n     = pos;
        tgt_n     = tgt_q;
        held_n    = held_q;
        item_n    = item_q;
        ready_n   = ready_q;
        move_n    = move_q;
        proc_n    = proc_q;
        proc_id_n = proc_id_q;
        err_n     = 1'b0;
        // Timer expiry lands first so a command on the same cycle sees its result.
        if (move_q != 8'd0) begin
            move_n = move_q - 8'd1;
            if (move_q == 8'd1) pos_n = tgt_q;
        end
        if (proc_q != 8'd0) begin
            proc_n = proc_q - 8'd1;
            if (proc_q == 8'd1) ready_n = ready_n | (ID_ONE << proc_id_q);
        end
        if (game_q == GS_RUN) item_n = item_n | DISPENSER_MASK;
        at_now  = (pos_n == tgt_q) && (move_n == 8'd0);
        item_at = |(item_n & tgt_oh);

        case (game_q)
            GS_IDLE: begin
                if (strobe.start) begin
                    game_n = GS_RUN;
                    pos_n  = TGT_FIRST;
                    tgt_n  = TGT_FIRST;
                end
            end
            GS_RUN: begin
                if (strobe.endgame) game_n = GS_ENDED;
                if (strobe.invalid) err_n = 1'b1;
                if (strobe.sel) begin
                    if (cmd_id >= TGT_FIRST && cmd_id <= BIN_ID) begin
                        tgt_n  = cmd_id;
                        move_n = 8'd0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                if (strobe.move && move_n == 8'd0 && tgt_q != pos_n) move_n = 8'(MOVE_CYCLES);
                if (strobe.get) begin
                    if (at_now && !held_q && item_at) begin
                        held_n = 1'b1;
                        if (!is_dispenser(tgt_q)) begin
                            item_n  = item_n & ~tgt_oh;
                            ready_n = ready_n & ~tgt_oh;
                        end
                        if (proc_n != 8'd0 && proc_id_q == tgt_q) proc_n = 8'd0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                if (strobe.put) begin
                    if (at_now && held_q && !item_at && tgt_q != BIN_ID) begin
                        held_n  = 1'b0;
                        item_n  = item_n | tgt_oh;
                        ready_n = ready_n & ~tgt_oh;
                        if (proc_n != 8'd0 && proc_id_q == tgt_q) proc_n = 8'd0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                if (strobe.throw_item) begin
                    if (held_q && is_throwable(tgt_q)) begin
                        held_n = 1'b0;
                        if (tgt_q != BIN_ID) item_n = item_n | tgt_oh;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                if (strobe.interact) begin
                    if (at_now && is_machine(tgt_q) && item_at && proc_n == 8'd0) begin
                        proc_n    = 8'(PROC_CYCLES);
                        proc_id_n = tgt_q;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Status is built from next state so a command shows up one cycle after it is sampled.
    assign tgt_n_oh = ID_ONE << tgt_n;
    assign at_next  = (game_n != GS_IDLE) && (pos_n == tgt_n) && (move_n == 8'd0);

    always_comb begin
        out_n           = '0;
        out_n[OB_RUN]   = (game_n == GS_RUN);
        out_n[OB_ERR]   = err_n;
        out_n[OB_AT]    = at_next;
        out_n[OB_HELD]  = held_n;
        out_n[OB_READY] = |(ready_n & tgt_n_oh);
        out_n[OB_ITEM]  = |(item_n & tgt_n_oh);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            game_q    <= GS_IDLE;
            pos       <= '0;
            tgt_q     <= '0;
            held_q    <= 1'b0;
            item_q    <= '0;
            ready_q   <= '0;
            move_q    <= '0;
            proc_q    <= '0;
            proc_id_q <= '0;
            out_bits  <= '0;
        end else begin
            game_q    <= game_n;
            pos       <= pos_n;
            tgt_q     <= tgt_n;
            held_q    <= held_n;
            item_q    <= item_n;
            ready_q   <= ready_n;
            move_q    <= move_n;
            proc_q    <= proc_n;
            proc_id_q <= proc_id_n;
            out_bits  <= out_n;
        end
    end

endmodule
